// File: rtl/lm75a_temp_bcd.sv
// LM75A temperature word to sign + BCD digits.
// The raw word from the I2C read stage is only accepted after it has been
// stable for STABLE_CYCLES clocks. It is then converted with an iterative
// shift-add-3 (double-dabble) FSM into registered digits for the display driver.
module lm75a_temp_bcd #(
   parameter int STABLE_CYCLES = 4096,
   parameter int CNT_W         = 13
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] data,
   output logic        sign,
   output logic [3:0]  bcd_hun,
   output logic [3:0]  bcd_ten,
   output logic [3:0]  bcd_one,
   output logic [11:0] bcd_frac,
   output logic        out_valid,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      DONE
   } state_t;

   localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);

   state_t           state;
   logic [15:0]      data_q;
   logic [15:0]      last_conv;
   logic [10:0]      conv_word;
   logic             first_pend;
   logic [CNT_W-1:0] stable_cnt;
   logic [19:0]      shift_reg;
   logic [3:0]       bit_cnt;
   logic             trigger;
   logic [10:0]      load_mag;
   logic [10:0]      conv_mag;

   // Magnitude of an 11-bit two's complement value; -1024 maps to 1024.
   function automatic logic [10:0] magnitude(input logic [10:0] raw);
      return raw[10] ? (~raw + 11'd1) : raw;
   endfunction

   // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
   function automatic logic [19:0] dd_step(input logic [19:0] s);
      logic [19:0] t;
      t = s;
      if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
      if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
      if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
      return {t[18:0], 1'b0};
   endfunction

   // Eighths of a degree as three BCD fractional digits.
   function automatic logic [11:0] frac_bcd(input logic [2:0] code);
      logic [11:0] f;
      f = 12'h000;
      case (code)
         3'd0: f = 12'h000;
         3'd1: f = 12'h125;
         3'd2: f = 12'h250;
         3'd3: f = 12'h375;
         3'd4: f = 12'h500;
         3'd5: f = 12'h625;
         3'd6: f = 12'h750;
         3'd7: f = 12'h875;
         default: f = 12'h000;
      endcase
      return f;
   endfunction

   assign load_mag = magnitude(data_q[15:5]);
   assign conv_mag = magnitude(conv_word);
   assign trigger  = (state == IDLE) && (stable_cnt == STABLE_MAX) &&
                     ((data_q != last_conv) || first_pend);

   // Stability qualifier: count clocks the input word has held, saturating.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_q     <= 16'h0000;
         stable_cnt <= '0;
      end else begin
         data_q <= data;
         if (data != data_q)
            stable_cnt <= '0;
         else if (stable_cnt != STABLE_MAX)
            stable_cnt <= stable_cnt + 1'b1;
      end
   end

   // Conversion FSM: latch the qualified word, shift-add-3 eight times, publish digits.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         busy       <= 1'b0;
         out_valid  <= 1'b0;
         sign       <= 1'b0;
         bcd_hun    <= 4'h0;
         bcd_ten    <= 4'h0;
         bcd_one    <= 4'h0;
         bcd_frac   <= 12'h000;
         last_conv  <= 16'h0000;
         conv_word  <= 11'h000;
         first_pend <= 1'b1;
         shift_reg  <= 20'h00000;
         bit_cnt    <= 4'h0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (trigger) begin
                  state <= LOAD;
                  busy  <= 1'b1;
               end
            end
            LOAD: begin
               conv_word  <= data_q[15:5];
               last_conv  <= data_q;
               first_pend <= 1'b0;
               shift_reg  <= {12'h000, load_mag[10:3]};
               bit_cnt    <= 4'd8;
               state      <= SHIFT;
            end
            SHIFT: begin
               shift_reg <= dd_step(shift_reg);
               bit_cnt   <= bit_cnt - 4'd1;
               if (bit_cnt == 4'd1)
                  state <= DONE;
            end
            DONE: begin
               bcd_hun   <= shift_reg[19:16];
               bcd_ten   <= shift_reg[15:12];
               bcd_one   <= shift_reg[11:8];
               bcd_frac  <= frac_bcd(conv_mag[2:0]);
               sign      <= conv_word[10] && (conv_mag != 11'd0);
               out_valid <= 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
